dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately.
REQ-003 SHALL have port req_valid  input  1  request present.
REQ-004 SHALL have port req_ready  output  1  responder can accept a request.
REQ-005 SHALL have port req_write  input  1  request type: 1 = store, 0 = load.
REQ-006 SHALL have port req_addr  input  64  byte address.
REQ-007 SHALL have port req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = double.
REQ-008 SHALL have port req_unsigned  input  1  1 = zero-extend load data, 0 = sign-extend load data.
REQ-009 SHALL have port req_wdata  input  64  store data; the value is right-aligned in the low bits.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-011 SHALL have port rsp_rdata  output  64  load result; 0 for stores and for error responses.
REQ-012 SHALL have port rsp_error  output  1  the request was rejected; valid only while rsp_valid=1.
REQ-013 SHALL have parameter DEPTH, default 256, meaning the number of 64-bit words in the internal array (DEPTH*8 bytes).

Function
REQ-014 SHALL hold an internal array of DEPTH x 64-bit words.
- Synchronous read, one-cycle latency.
- Single write port.
- Little-endian byte lanes selected by req_addr[2:0].
REQ-015 SHALL assert req_ready only in state IDLE; a request is accepted in cycle T when req_valid=1 and req_ready=1.
REQ-016 SHALL register req_write, req_addr, req_size, req_unsigned and req_wdata on acceptance; input changes after T SHALL have no effect.
REQ-017 SHALL flag an error at acceptance when either condition holds:
- the address is misaligned (req_addr is not a multiple of 2^req_size);
- the word index req_addr[63:3] is >= DEPTH.
REQ-018 SHALL implement states IDLE, RD_WAIT, RD_RESP, ST_READ, ST_WRITE and ERR_RESP.
REQ-019 SHALL, on acceptance, move from IDLE to:
- ERR_RESP if the request is in error;
- RD_WAIT for a load;
- ST_WRITE for a double store;
- ST_READ for any other store.
REQ-020 SHALL make these unconditional transitions: RD_WAIT->RD_RESP, RD_RESP->IDLE, ST_READ->ST_WRITE, ST_WRITE->IDLE, ERR_RESP->IDLE.
REQ-021 Load: SHALL issue the array read in RD_WAIT and assert rsp_valid in RD_RESP (cycle T+2).
- rsp_rdata is the selected field, shifted down by 8*addr[2:0].
- The field is extended per req_unsigned; a double is returned unmodified.
REQ-022 Double store: SHALL write req_wdata to the word in ST_WRITE and assert rsp_valid in that cycle (T+1).
REQ-023 Byte, half or word store: SHALL read the word in ST_READ, then in ST_WRITE (cycle T+2):
- replace only the addressed bytes with the low bytes of req_wdata;
- write the merged word back;
- assert rsp_valid.
Other bytes SHALL be unchanged.
REQ-024 Error: SHALL assert rsp_valid=1 and rsp_error=1 in ERR_RESP (T+1), with rsp_rdata=0, and SHALL make no array write.
REQ-025 SHALL hold rsp_valid=0, rsp_error=0 and rsp_rdata=0 in every state not named above as responding.
REQ-026 SHALL have no response backpressure; the requester samples rsp_* in the rsp_valid cycle only.
REQ-027 A new request SHALL be acceptable in the cycle immediately after any response (back-to-back throughput).
REQ-028 SHALL return the just-written data on a load issued right after a store to the same address (no stale read).

Reset
REQ-029 SHALL, while reset=0, drive state=IDLE, req_ready=1, rsp_valid=0, rsp_error=0 and rsp_rdata=0, and clear all captured request registers.
REQ-030 SHALL NOT initialise array contents on reset.
REQ-031 SHALL, on reset asserted mid-operation, abandon the operation with no response and no array write, unless the write edge of ST_WRITE has already passed.

Verification
REQ-032 Double store then load: store addr 0x10, size 11, wdata 0x1122334455667788 -> rsp_valid at T+1. Then load addr 0x10, size 11 -> rsp_valid at T+2 with rdata 0x1122334455667788.
REQ-033 Byte store merge: after REQ-032, store addr 0x13, size 00, wdata 0xAB. Then load addr 0x10, size 11 -> rdata 0x11223344AB667788; the store response is at T+2.
REQ-034 Sign and zero extension: word at 0x20 = 0x00000000FFFF8001.
- Load addr 0x20, size 01, signed -> 0xFFFFFFFFFFFF8001.
- Same load with unsigned -> 0x0000000000008001.
- Load addr 0x22, size 00, unsigned -> 0x00000000000000FF.
REQ-035 Errors: load addr 0x21, size 01 -> rsp_valid and rsp_error at T+1, rdata 0. Store addr DEPTH*8, size 11 -> error response, and a re-read of every word shows no array change.
REQ-036 Reset mid-operation: assert reset=0 during ST_READ of a byte store to 0x30 -> no rsp_valid, req_ready=1 immediately; word 0x30 is unchanged.
REQ-037 Handshake: hold req_valid=1 with changing inputs during a load -> req_ready=0 until the cycle after the response, and the response reflects only the captured request.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between a requester and dmem_responder.
//   req_valid/req_ready : request handshake (accepted when both are 1)
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_size            : 00 byte, 01 half, 10 word, 11 double
//   req_unsigned        : 1 = zero-extend load data, 0 = sign-extend
//   req_wdata           : store data, right-aligned
//   rsp_valid           : one-cycle response pulse, no backpressure
//   rsp_rdata           : load result (0 for stores and errors)
//   rsp_error           : request rejected (meaningful only with rsp_valid)
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: DEPTH x 64-bit array serving one load/store at a time.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : dmem_responder_if.slave (request handshake + response pulse)
// Loads respond at T+2, double stores at T+1, narrower stores at T+2 (read-
// modify-write), errors (misaligned or out of range) at T+1 with no write.
module dmem_responder #(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, ST_READ, ST_WRITE, ERR_RESP
  } state_t;

  state_t        state;
  logic          write_q;
  // Upper address bits only matter for the range check made at acceptance,
  // so just the word index and byte offset are kept.
  logic [AW+2:0] addr_q;
  logic [1:0]    size_q;
  logic          unsigned_q;
  logic [63:0]   wdata_q;

  logic [63:0]   mem [DEPTH];
  logic [63:0]   rd_word;

  logic          misaligned, out_of_range, req_err, accept;
  logic [2:0]    align_mask;
  logic [AW-1:0] idx;
  logic [5:0]    bit_off;
  logic [63:0]   shifted, load_data, byte_mask, wshift, merged;
  logic [7:0]    lane_mask;

  // Acceptance-time checks work on the live request.
  always_comb begin
    align_mask = 3'b000;
    case (bus.req_size)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      2'd3: align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
  end

  assign misaligned   = |(bus.req_addr[2:0] & align_mask);
  assign out_of_range = bus.req_addr[63:3] >= 61'(DEPTH);
  assign req_err      = misaligned | out_of_range;
  assign accept       = bus.req_valid & bus.req_ready;

  assign idx     = addr_q[AW+2:3];
  assign bit_off = {addr_q[2:0], 3'b000};

  // Control FSM; req_ready, rsp_valid and rsp_error are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_error <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      wdata_q       <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_error <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          write_q       <= bus.req_write;
          addr_q        <= bus.req_addr[AW+2:0];
          size_q        <= bus.req_size;
          unsigned_q    <= bus.req_unsigned;
          wdata_q       <= bus.req_wdata;
          bus.req_ready <= 1'b0;
          if (req_err) begin
            state         <= ERR_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= 1'b1;
          end else if (!bus.req_write) begin
            state <= RD_WAIT;
          end else if (bus.req_size == 2'd3) begin
            state         <= ST_WRITE;
            bus.rsp_valid <= 1'b1;
          end else begin
            state <= ST_READ;
          end
        end
        RD_WAIT: begin
          state         <= RD_RESP;
          bus.rsp_valid <= 1'b1;
        end
        ST_READ: begin
          state         <= ST_WRITE;
          bus.rsp_valid <= 1'b1;
        end
        RD_RESP, ST_WRITE, ERR_RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array: synchronous read in RD_WAIT/ST_READ, write in ST_WRITE. A reset
  // forces state to IDLE at once, so an interrupted store never writes.
  always_ff @(posedge clk) begin
    if (state == RD_WAIT || state == ST_READ)
      rd_word <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (state == ST_WRITE)
      mem[idx] <= merged;
  end

  // Load extraction: shift addressed field to bit 0 then extend.
  assign shifted = rd_word >> bit_off;

  always_comb begin
    load_data = shifted;
    case (size_q)
      2'd0: load_data = unsigned_q ? {56'd0, shifted[7:0]}
                                   : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: load_data = unsigned_q ? {48'd0, shifted[15:0]}
                                   : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_data = unsigned_q ? {32'd0, shifted[31:0]}
                                   : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  assign bus.rsp_rdata = (state == RD_RESP) ? load_data : 64'd0;

  // Store merge: a double has an all-ones mask, so the stale rd_word seen in
  // its ST_WRITE cycle is fully replaced.
  always_comb begin
    lane_mask = 8'h00;
    case (size_q)
      2'd0: lane_mask = 8'h01;
      2'd1: lane_mask = 8'h03;
      2'd2: lane_mask = 8'h0F;
      2'd3: lane_mask = 8'hFF;
      default: lane_mask = 8'h00;
    endcase
    lane_mask = lane_mask << addr_q[2:0];
    for (int b = 0; b < 8; b++)
      byte_mask[8*b +: 8] = {8{lane_mask[b]}};
  end

  assign wshift = wdata_q << bit_off;
  assign merged = (rd_word & ~byte_mask) | (wshift & byte_mask);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model, expected-response
// queue filled at issue time, independent monitor checking every cycle.
module tb_dmem_responder;
  localparam int DEPTH = 16;
  localparam int NB    = DEPTH * 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem_b [NB];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, req, $time);
    end
  endfunction

  // Little-endian byte gather with optional sign extension.
  function automatic logic [63:0] mload(logic [63:0] addr, int n, bit uns);
    logic [63:0] v = '0;
    int b = int'(addr);
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[b + i];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Called in the cycle the request is presented (accepted at the next edge).
  function automatic void push_exp(bit wr, logic [63:0] addr, logic [1:0] sz,
                                   bit uns, logic [63:0] wd);
    exp_t e;
    int   n = 1 << sz;
    bit   err = ((addr & 64'(n - 1)) != 0) || ((addr >> 3) >= 64'(DEPTH));
    e.err   = err;
    e.rdata = '0;
    if (err) e.due = cyc + 1;
    else if (!wr) begin
      e.due   = cyc + 2;
      e.rdata = mload(addr, n, uns);
    end else begin
      e.due = cyc + ((n == 8) ? 1 : 2);
      for (int i = 0; i < n; i++) mem_b[int'(addr) + i] = wd[8*i +: 8];
    end
    exp_q.push_back(e);
  endfunction

  task automatic drive(bit wr, logic [63:0] addr, logic [1:0] sz, bit uns,
                       logic [63:0] wd);
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    int guard = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 50);
    if (!ok) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(bit wr, logic [63:0] addr, logic [1:0] sz, bit uns,
                       logic [63:0] wd);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    drive(wr, addr, sz, uns, wd);
    push_exp(wr, addr, sz, uns, wd);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per response, checks idle outputs otherwise.
  initial begin : mon
    exp_t e;
    bit   prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) chk("ready_after_rsp", 64'(bus.req_ready), 64'd1);
      prev = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        prev = 1'b1;
        if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          chk("rsp_error", 64'(bus.rsp_error), 64'(e.err));
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        end
      end else begin
        chk("idle_error", 64'(bus.rsp_error), 64'd0);
        chk("idle_rdata", bus.rsp_rdata, 64'd0);
      end
    end
  end

  initial begin : stim
    bit          ok;
    int          r, n;
    logic [1:0]  sz;
    logic [63:0] addr;

    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = '0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;

    repeat (2) @(negedge clk);
    chk("reset_ready",     64'(bus.req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_error", 64'(bus.rsp_error), 64'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata,      64'd0);
    reset = 1'b1;

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++)
      issue(1'b1, 64'(w * 8), 2'd3, 1'b0, {$urandom, $urandom});

    // Double store then load, then byte merge.
    issue(1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788);
    issue(1'b0, 64'h10, 2'd3, 1'b0, 64'd0);
    issue(1'b1, 64'h13, 2'd0, 1'b0, 64'hAB);
    issue(1'b0, 64'h10, 2'd3, 1'b0, 64'd0);

    // Sign / zero extension.
    issue(1'b1, 64'h20, 2'd3, 1'b0, 64'h00000000FFFF8001);
    issue(1'b0, 64'h20, 2'd1, 1'b0, 64'd0);
    issue(1'b0, 64'h20, 2'd1, 1'b1, 64'd0);
    issue(1'b0, 64'h22, 2'd0, 1'b1, 64'd0);

    // Errors: misaligned load, out-of-range store, then full re-read.
    issue(1'b0, 64'h21, 2'd1, 1'b0, 64'd0);
    issue(1'b1, 64'(NB), 2'd3, 1'b0, '1);
    for (int w = 0; w < DEPTH; w++)
      issue(1'b0, 64'(w * 8), 2'd3, 1'b0, 64'd0);

    // Reset during ST_READ of a byte store: no response, no write.
    wait_ready(ok);
    if (ok) begin
      drive(1'b1, 64'h30, 2'd0, 1'b0, 64'h5A);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("midreset_ready",     64'(bus.req_ready), 64'd1);
      chk("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
    end
    issue(1'b0, 64'h30, 2'd3, 1'b0, 64'd0);

    // Held req_valid with changing inputs during a load.
    wait_ready(ok);
    if (ok) begin
      drive(1'b0, 64'h10, 2'd3, 1'b0, 64'd0);
      push_exp(1'b0, 64'h10, 2'd3, 1'b0, 64'd0);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk("hold_ready_low", 64'(bus.req_ready), 64'd0);
        drive(1'($urandom), {$urandom, $urandom}, 2'($urandom), 1'($urandom),
              {$urandom, $urandom});
      end
      @(negedge clk);
      chk("hold_ready_high", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
    end

    // Randomized traffic, mostly legal with some misaligned / out of range.
    for (int t = 0; t < 250; t++) begin
      sz = 2'($urandom_range(0, 3));
      n  = 1 << sz;
      r  = $urandom_range(0, 9);
      if (r < 7)       addr = 64'($urandom_range(0, NB - 1)) & ~64'(n - 1);
      else if (r == 7) addr = 64'($urandom_range(0, NB - 1));
      else if (r == 8) addr = 64'(NB + $urandom_range(0, 63));
      else             addr = {$urandom, $urandom};
      issue(1'($urandom), addr, sz, 1'($urandom), {$urandom, $urandom});
    end

    for (int w = 0; w < DEPTH; w++)
      issue(1'b0, 64'(w * 8), 2'd3, 1'b0, 64'd0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      chk("missing_rsp", 64'd0, 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
